sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter_pkg.sv | 20 ++
 rtl/sram_like_arbiter_rr_pick2.sv | 22 ++
 rtl/sram_like_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the two-master SRAM-like arbiter: FSM states, grant IDs
// and transfer size codes.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that did not win last time. req[0] is the instruction side, req[1] the data side.
module rr_pick2
  import sram_like_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_e       last,
  output gnt_e       gnt
);

  // Grant selection
  always_comb begin
    gnt = GNT_INST;
    case (req)
      2'b01:   gnt = GNT_INST;
      2'b10:   gnt = GNT_DATA;
      2'b11:   gnt = (last == GNT_INST) ? GNT_DATA : GNT_INST;
      default: gnt = GNT_INST;
    endcase
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates an instruction and a data master onto one SRAM-like downstream
// port, keeping exactly one transaction outstanding (IDLE -> REQ -> WAIT).
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,

  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,

  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata
);

  state_e state_r;
  gnt_e   gnt_r;
  gnt_e   last_r;
  gnt_e   pick_s;

  rr_pick2 u_pick (
    .req  ({data_req, inst_req}),
    .last (last_r),
    .gnt  (pick_s)
  );

  // Arbitration FSM; grant and round-robin history latch on leaving IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      gnt_r   <= GNT_INST;
      last_r  <= GNT_INST;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            gnt_r   <= pick_s;
            last_r  <= pick_s;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_addr_ok) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // a stray mem_data_ok outside WAIT falls through untouched
          if (mem_data_ok) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Downstream request mux and per-side handshake steering
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = inst_wr;
    mem_size     = inst_size;
    mem_addr     = inst_addr;
    mem_wdata    = inst_wdata;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (gnt_r == GNT_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
    case (state_r)
      ST_REQ: begin
        mem_req      = 1'b1;
        inst_addr_ok = (gnt_r == GNT_INST) && mem_addr_ok;
        data_addr_ok = (gnt_r == GNT_DATA) && mem_addr_ok;
      end
      ST_WAIT: begin
        inst_data_ok = (gnt_r == GNT_INST) && mem_data_ok;
        data_data_ok = (gnt_r == GNT_DATA) && mem_data_ok;
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench: table of arbitration vectors with a response scoreboard,
// plus hand-written reset-in-flight and stray-data_ok sequences.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  sram_like_arbiter #(.DW(32), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] INST_WDATA = 32'h5A5A_0000;

  typedef struct {
    logic        ireq;
    logic        dreq;
    int          stall;
    logic        gnt;     // 0 = instruction side, 1 = data side
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        dwr;
    logic [1:0]  dsize;
    logic [31:0] dwdata;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        gnt;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Pops the scoreboard when a data_ok appears and compares side and data
  task automatic collect();
    exp_t e;
    total++;
    if (!inst_data_ok && !data_data_ok) begin
      bad++;
      $display("FAIL data_ok_missing: got=00 expected=one side at %0t", $time);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: got=data_ok expected=none at %0t", $time);
    end else begin
      e = sb.pop_front();
      check("dok_side", {62'd0, inst_data_ok, data_data_ok}, e.gnt ? 64'd1 : 64'd2);
      check("rdata", e.gnt ? data_rdata : inst_rdata, e.rdata);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    inst_req = v.ireq; data_req = v.dreq;
    inst_addr = v.iaddr; data_addr = v.daddr;
    data_wr = v.dwr; data_size = v.dsize; data_wdata = v.dwdata;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    check("idle_mem_req", mem_req, 1'b0);
    sb.push_back('{gnt: v.gnt, rdata: v.rdata});
    for (int w = 0; w <= v.stall; w++) begin
      @(negedge clk);
      mem_addr_ok = (w == v.stall);
      #1;
      check("req_mem_req", mem_req, 1'b1);
      check("req_mem_addr", mem_addr, v.gnt ? v.daddr : v.iaddr);
      check("req_mem_wr", mem_wr, v.gnt ? v.dwr : 1'b0);
      check("req_mem_size", mem_size, v.gnt ? v.dsize : 2'd2);
      check("req_mem_wdata", mem_wdata, v.gnt ? v.dwdata : INST_WDATA);
      check("addr_ok", {inst_addr_ok, data_addr_ok},
            (w == v.stall) ? (v.gnt ? 2'b01 : 2'b10) : 2'b00);
    end
    @(negedge clk);
    mem_addr_ok = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("wait_mem_req", mem_req, 1'b0);
    check("wait_no_dok", {inst_data_ok, data_data_ok}, 2'b00);
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = v.rdata;
    #1;
    collect();
    @(posedge clk);
    #1;
    mem_data_ok = 1'b0; inst_req = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 0, 1'b0, 32'hBFC0_0000, 32'h8000_0000, 1'b0, 2'd2, 32'h0, 32'h3C1D_0000};
    vecs[1] = '{1'b1, 1'b1, 0, 1'b1, 32'hBFC0_0004, 32'h8000_1000, 1'b0, 2'd2, 32'h0, 32'h1111_0001};
    vecs[2] = '{1'b1, 1'b1, 1, 1'b0, 32'hBFC0_0008, 32'h8000_1004, 1'b0, 2'd2, 32'h0, 32'h2222_0002};
    vecs[3] = '{1'b1, 1'b1, 0, 1'b1, 32'hBFC0_000C, 32'h8000_1008, 1'b1, 2'd1, 32'h0000_BEEF, 32'h3333_0003};
    vecs[4] = '{1'b1, 1'b1, 2, 1'b0, 32'hBFC0_0010, 32'h8000_100C, 1'b0, 2'd2, 32'h0, 32'h4444_0004};
    vecs[5] = '{1'b0, 1'b1, 5, 1'b1, 32'hBFC0_0014, 32'h8000_0003, 1'b1, 2'd0, 32'h0000_00AB, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 2, 1'b0, 32'hBFC0_0018, 32'h8000_2000, 1'b0, 2'd2, 32'h0, 32'h6666_0006};
    vecs[7] = '{1'b1, 1'b1, 0, 1'b1, 32'hBFC0_001C, 32'h8000_2004, 1'b0, 2'd2, 32'h0, 32'h7777_0007};

    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1;
    inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0; inst_wdata = INST_WDATA;
    data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 4'b0000);
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Stray mem_data_ok while idle must not move the FSM or leak a handshake
    @(negedge clk);
    mem_data_ok = 1'b1; #1;
    check("stray_idle_dok", {inst_data_ok, data_data_ok, mem_req}, 3'b000);
    @(negedge clk);
    mem_data_ok = 1'b0; #1;
    check("stray_idle_state", mem_req, 1'b0);

    // Stray mem_data_ok while in REQ is ignored
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    sb.push_back('{gnt: 1'b0, rdata: 32'hCAFE_0001});
    @(negedge clk);
    mem_data_ok = 1'b1; #1;
    check("stray_req_dok", {inst_data_ok, data_data_ok}, 2'b00);
    check("stray_req_mem_req", mem_req, 1'b1);
    @(negedge clk);
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1; #1;
    check("stray_req_still_req", {mem_req, inst_addr_ok}, 2'b11);
    @(negedge clk);
    mem_addr_ok = 1'b0; inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
    collect();
    @(posedge clk); #1;
    mem_data_ok = 1'b0;

    // Reset during WAIT drops the transaction and restores last_grant
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h8000_3000; data_wr = 1'b0; data_size = 2'd2;
    @(negedge clk);
    mem_addr_ok = 1'b1; #1;
    check("rw_addr_ok", data_addr_ok, 1'b1);
    @(negedge clk);
    mem_addr_ok = 1'b0; data_req = 1'b0; inst_req = 1'b1; reset = 1'b1; #1;
    check("rw_rst_outs", {mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 5'b00000);
    @(negedge clk);
    reset = 1'b0; inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_0BAD; #1;
    check("rw_no_dok", {inst_data_ok, data_data_ok, mem_req}, 3'b000);
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    run_vec('{1'b1, 1'b1, 0, 1'b1, 32'hBFC0_0200, 32'h8000_4000, 1'b0, 2'd2, 32'h0, 32'h9999_0009});

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
